seg_display_scan: RTL and testbench

//  Downstream display stage for the toy processor. Captures the processor's
//  8-bit memory address and 8-bit data output on a load strobe, then drives
//  the 4-digit seven-segment display in hex by time-multiplexing.

---
 rtl/seg_display_scan.sv | 124 ++++++++++++
 tb/tb_seg_display_scan.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Four-digit hex seven-segment scanner for the toy processor: captures address/data
// on LOAD and time-multiplexes them onto the display with a per-slot blanking window.
module seg_display_scan #(
  parameter int REFRESH_CNT = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int CNT_W       = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [7:0] ADD,
  input  logic [7:0] D_OUT,
  output logic [6:0] seven_seg_out,
  output logic       EN_L,
  output logic       EN_ML,
  output logic       EN_MR,
  output logic       EN_R
);

  typedef enum logic [1:0] {
    DIG_L  = 2'd0,
    DIG_ML = 2'd1,
    DIG_MR = 2'd2,
    DIG_R  = 2'd3
  } digit_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  digit_t           digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_add_q, shadow_dat_q;
  logic [3:0]       nibble;
  logic             blank_d;
  logic [3:0]       en_d, en_q;   // {L, ML, MR, R}, active-low
  logic [6:0]       seg_d, seg_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shadow_add_q <= 8'h00;
      shadow_dat_q <= 8'h00;
    end else if (LOAD) begin
      shadow_add_q <= ADD;
      shadow_dat_q <= D_OUT;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= '0;
      digit_q <= DIG_L;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      unique case (digit_q)
        DIG_L:   digit_d = DIG_ML;
        DIG_ML:  digit_d = DIG_MR;
        DIG_MR:  digit_d = DIG_R;
        default: digit_d = DIG_L;
      endcase
    end
  end

  // Outputs are computed from the next counter/digit so the registered enables
  // line up with the counter value they represent.
  always_comb begin
    blank_d = (cnt_d < BLANK_END);
    nibble  = shadow_dat_q[3:0];
    en_d    = 4'b1111;
    unique case (digit_d)
      DIG_L:   begin nibble = shadow_add_q[7:4]; en_d = 4'b0111; end
      DIG_ML:  begin nibble = shadow_add_q[3:0]; en_d = 4'b1011; end
      DIG_MR:  begin nibble = shadow_dat_q[7:4]; en_d = 4'b1101; end
      default: begin nibble = shadow_dat_q[3:0]; en_d = 4'b1110; end
    endcase

    unique case (nibble)
      4'h0:    seg_d = 7'h01;
      4'h1:    seg_d = 7'h4F;
      4'h2:    seg_d = 7'h12;
      4'h3:    seg_d = 7'h06;
      4'h4:    seg_d = 7'h4C;
      4'h5:    seg_d = 7'h24;
      4'h6:    seg_d = 7'h20;
      4'h7:    seg_d = 7'h0F;
      4'h8:    seg_d = 7'h00;
      4'h9:    seg_d = 7'h04;
      4'hA:    seg_d = 7'h08;
      4'hB:    seg_d = 7'h60;
      4'hC:    seg_d = 7'h31;
      4'hD:    seg_d = 7'h42;
      4'hE:    seg_d = 7'h30;
      default: seg_d = 7'h38;
    endcase

    // Blank window: all digits dark to hide the previous digit's segments.
    if (blank_d) begin
      en_d  = 4'b1111;
      seg_d = 7'h7F;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en_q  <= 4'b1111;
      seg_q <= 7'h7F;
    end else begin
      en_q  <= en_d;
      seg_q <= seg_d;
    end
  end

  assign {EN_L, EN_ML, EN_MR, EN_R} = en_q;
  assign seven_seg_out              = seg_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: a cycle model pushes expected {enables, segments}
// into a queue on every clock edge; each scenario task pops and compares.
module tb_seg_display_scan;

  localparam int REFRESH_CNT = 8;
  localparam int BLANK_CYC   = 2;
  localparam int CNT_W       = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] add   = 8'h00;
  logic [7:0] d_out = 8'h00;
  logic [6:0] seg;
  logic       en_l, en_ml, en_mr, en_r;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];

  // Reference model state: position in the scan and the captured values.
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [7:0] m_sa  = 8'h00;
  logic [7:0] m_sd  = 8'h00;

  always #5 clk = ~clk;

  seg_display_scan #(
    .REFRESH_CNT(REFRESH_CNT),
    .BLANK_CYC  (BLANK_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .LOAD         (load),
    .ADD          (add),
    .D_OUT        (d_out),
    .seven_seg_out(seg),
    .EN_L         (en_l),
    .EN_ML        (en_ml),
    .EN_MR        (en_mr),
    .EN_R         (en_r)
  );

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'b0000001;
      4'h1: dec = 7'b1001111;
      4'h2: dec = 7'b0010010;
      4'h3: dec = 7'b0000110;
      4'h4: dec = 7'b1001100;
      4'h5: dec = 7'b0100100;
      4'h6: dec = 7'b0100000;
      4'h7: dec = 7'b0001111;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0000100;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b1100000;
      4'hC: dec = 7'b0110001;
      4'hD: dec = 7'b1000010;
      4'hE: dec = 7'b0110000;
      default: dec = 7'b0111000;
    endcase
  endfunction

  function automatic logic [10:0] observed();
    return {en_l, en_ml, en_mr, en_r, seg};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, queue the
  // expected outputs, and return at the following falling edge.
  task automatic step(input logic l, input logic [7:0] a, input logic [7:0] d);
    logic [3:0]  nib;
    logic [10:0] e;
    load  = l;
    add   = a;
    d_out = d;
    @(posedge clk);
    if (m_cnt == REFRESH_CNT - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt = m_cnt + 1;
    end
    case (m_idx)
      0:       nib = m_sa[7:4];
      1:       nib = m_sa[3:0];
      2:       nib = m_sd[7:4];
      default: nib = m_sd[3:0];
    endcase
    if (m_cnt < BLANK_CYC) e = {4'b1111, 7'h7F};
    else                   e = {~(4'b1000 >> m_idx), dec(nib)};
    if (l) begin
      m_sa = a;
      m_sd = d;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Idle until the model sits at (idx, cnt); queued expectations are dropped.
  task automatic seek(input int idx, input int cnt, output bit ok);
    logic [10:0] e;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (m_idx == idx && m_cnt == cnt) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, add, d_out);
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    logic [10:0] e, got;
    int first_l, count_l, first_ml;
    rst_n = 1'b0;
    m_cnt = 0; m_idx = 0; m_sa = 8'h00; m_sd = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== {4'b1111, 7'h7F}) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %b expected %b", i, observed(), {4'b1111, 7'h7F});
      end
    end
    rst_n    = 1'b1;
    first_l  = -1;
    count_l  = 0;
    first_ml = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 8'h00, 8'h00);
      e   = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got %b expected %b", i, got, e);
      end
      if (en_l == 1'b0) begin
        count_l++;
        if (first_l < 0) first_l = i;
      end
      if (en_ml == 1'b0 && first_ml < 0) first_ml = i;
    end
    checks++;
    if (first_l !== 2) begin errors++; $display("FAIL first_en_l: got cycle %0d expected 2", first_l); end
    checks++;
    if (count_l !== 6) begin errors++; $display("FAIL en_l_len: got %0d expected 6", count_l); end
    checks++;
    if (first_ml !== 10) begin errors++; $display("FAIL first_en_ml: got cycle %0d expected 10", first_ml); end
  endtask

  // Load coincides with the R->L wrap, then one scan is observed.
  task automatic test_pattern();
    logic [10:0] e, got;
    logic [6:0]  seen [4];
    bit ok;
    for (int k = 0; k < 4; k++) seen[k] = 7'h7F;
    seek(3, 7, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pattern_seek: got timeout expected slot R"); end
    step(1'b1, 8'h3A, 8'h7F);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL pattern_wrap_load: got %b expected %b", observed(), e); end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 8'h00, 8'h00);
      e   = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pattern cyc %0d: got %b expected %b", i, got, e);
      end
      if (!en_l)  seen[0] = seg;
      if (!en_ml) seen[1] = seg;
      if (!en_mr) seen[2] = seg;
      if (!en_r)  seen[3] = seg;
    end
    checks++;
    if (seen[0] !== 7'b0000110) begin errors++; $display("FAIL pattern_L: got %b expected 0000110", seen[0]); end
    checks++;
    if (seen[1] !== 7'b0001000) begin errors++; $display("FAIL pattern_ML: got %b expected 0001000", seen[1]); end
    checks++;
    if (seen[2] !== 7'b0001111) begin errors++; $display("FAIL pattern_MR: got %b expected 0001111", seen[2]); end
    checks++;
    if (seen[3] !== 7'b0111000) begin errors++; $display("FAIL pattern_R: got %b expected 0111000", seen[3]); end
  endtask

  task automatic test_free_run();
    logic [10:0] e, got;
    int blanks;
    blanks = 0;
    for (int i = 0; i < 4 * 4 * REFRESH_CNT; i++) begin
      step(1'b0, 8'h00, 8'h00);
      e   = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL free_run cyc %0d: got %b expected %b", i, got, e);
      end
      checks++;
      if ($countones(~got[10:7]) > 1) begin
        errors++;
        $display("FAIL one_hot cyc %0d: got enables %b expected at most one low", i, got[10:7]);
      end
      if (got[10:7] == 4'b1111) blanks++;
    end
    checks++;
    if (blanks !== 16 * BLANK_CYC) begin
      errors++;
      $display("FAIL blank_count: got %0d expected %0d", blanks, 16 * BLANK_CYC);
    end
  endtask

  task automatic test_load_mid_r();
    logic [10:0] e;
    bit ok;
    seek(3, 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL load_r_seek: got timeout expected slot R"); end
    step(1'b1, 8'h3A, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || seg !== 7'b0111000 || en_r !== 1'b0) begin
      errors++;
      $display("FAIL load_r_edge: got %b expected %b", observed(), {4'b1110, 7'b0111000});
    end
    step(1'b0, 8'h00, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || seg !== 7'b0000001 || en_r !== 1'b0) begin
      errors++;
      $display("FAIL load_r_update: got %b expected %b", observed(), {4'b1110, 7'b0000001});
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e, got;
    bit ok;
    seek(2, 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_seek: got timeout expected slot MR"); end
    checks++;
    if (en_mr !== 1'b0) begin errors++; $display("FAIL reset_mid_pre: got en_mr %b expected 0", en_mr); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== {4'b1111, 7'h7F}) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected %b", observed(), {4'b1111, 7'h7F});
    end
    m_cnt = 0; m_idx = 0; m_sa = 8'h00; m_sd = 8'h00;
    load  = 1'b1;
    add   = 8'hFF;
    d_out = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== {4'b1111, 7'h7F}) begin
        errors++;
        $display("FAIL reset_mid_hold cyc %0d: got %b expected %b", i, observed(), {4'b1111, 7'h7F});
      end
    end
    load  = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 2 * REFRESH_CNT; i++) begin
      step(1'b0, 8'hFF, 8'hFF);
      e   = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_run cyc %0d: got %b expected %b", i, got, e);
      end
      if (i == BLANK_CYC) begin
        checks++;
        if (got !== {4'b0111, 7'b0000001}) begin
          errors++;
          $display("FAIL reset_mid_restart: got %b expected %b", got, {4'b0111, 7'b0000001});
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [10:0] e;
    bit ok;
    for (int v = 0; v < 16; v++) begin
      seek(0, 4, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sweep_seek %0d: got timeout expected slot L", v); end
      step(1'b1, {4'h5, 4'(v)}, 8'h00);
      e = exp_q.pop_front();
      seek(1, 5, ok);
      checks++;
      if (!ok || en_ml !== 1'b0 || seg !== dec(4'(v))) begin
        errors++;
        $display("FAIL sweep_ml %0d: got en_ml=%b seg=%b expected en_ml=0 seg=%b", v, en_ml, seg, dec(4'(v)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_free_run();
    test_load_mid_r();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
